// File: rtl/writeback_stage_pkg.sv
// Shared instruction-record types for the back end of the pipeline, plus the
// retire/redirect classification used by the writeback stage.
package writeback_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] reg_data_t;

  typedef enum logic [2:0] {
    EXCEPT_NONE    = 3'd0,
    EXCEPT_MISPRED = 3'd1,
    EXCEPT_FLUSH   = 3'd2,
    EXCEPT_SYS     = 3'd3,
    EXCEPT_ILLEGAL = 3'd4,
    EXCEPT_FAULT   = 3'd5
  } except_code_t;

  typedef struct packed {
    logic         valid;
    except_code_t code;
  } except_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       rd_wen;
  } decode_t;

  typedef struct packed {
    logic      valid;
    reg_data_t pc;
    decode_t   decode;
    except_t   except;
  } issued_instr_t;

  typedef enum logic [2:0] {
    WB_NONE    = 3'd0,
    WB_COMMIT  = 3'd1,
    WB_MISPRED = 3'd2,
    WB_REFETCH = 3'd3,
    WB_DROP    = 3'd4
  } wb_class_t;

  function automatic issued_instr_t compose_issued_instr(
    input logic         valid,
    input reg_data_t    pc,
    input logic [4:0]   rd,
    input logic         rd_wen,
    input logic         exc_valid,
    input except_code_t exc_code
  );
    issued_instr_t r;
    r.valid         = valid;
    r.pc            = pc;
    r.decode.rd     = rd;
    r.decode.rd_wen = rd_wen;
    r.except.valid  = exc_valid;
    r.except.code   = exc_code;
    return r;
  endfunction

  // The code field only matters when except.valid is set; SYS still retires.
  function automatic wb_class_t classify_instr(input issued_instr_t instr);
    wb_class_t cls;
    cls = WB_NONE;
    if (!instr.valid) begin
      cls = WB_NONE;
    end else if (!instr.except.valid) begin
      cls = WB_COMMIT;
    end else begin
      case (instr.except.code)
        EXCEPT_SYS:     cls = WB_COMMIT;
        EXCEPT_MISPRED: cls = WB_MISPRED;
        EXCEPT_FLUSH:   cls = WB_REFETCH;
        default:        cls = WB_DROP;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/writeback_stage.sv
// Final pipeline stage: register-file writeback, retire counting and
// redirect/flush generation for mispredicts and refetch requests.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  issued_instr_t i_instr,
  input  reg_data_t     i_data,
  output logic          o_rf_wen,
  output logic [4:0]    o_rf_idx,
  output reg_data_t     o_rf_data,
  output logic          o_flush,
  output logic          o_redirect_valid,
  output reg_data_t     o_redirect_pc,
  output logic          o_instret_inc,
  output logic [63:0]   o_retired
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rf_wen_q, rf_wen_d;
  logic [4:0]  rf_idx_q, rf_idx_d;
  reg_data_t   rf_data_q, rf_data_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  reg_data_t   redirect_pc_q, redirect_pc_d;
  logic        instret_inc_q, instret_inc_d;
  logic [63:0] retired_q, retired_d;
  wb_class_t   cls_s;

  assign cls_s = classify_instr(i_instr);

  // Next-state and next-output computation; index/data/pc hold between strobes.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    rf_wen_d         = 1'b0;
    rf_idx_d         = rf_idx_q;
    rf_data_d        = rf_data_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    instret_inc_d    = 1'b0;
    retired_d        = retired_q;
    case (state_q)
      ST_IDLE: begin
        case (cls_s)
          WB_COMMIT: begin
            instret_inc_d = 1'b1;
            retired_d     = retired_q + 64'd1;
            if (i_instr.decode.rd_wen && (i_instr.decode.rd != 5'd0)) begin
              rf_wen_d  = 1'b1;
              rf_idx_d  = i_instr.decode.rd;
              rf_data_d = i_data;
            end else begin
              rf_wen_d  = 1'b0;
            end
          end
          WB_MISPRED: begin
            instret_inc_d    = 1'b1;
            retired_d        = retired_q + 64'd1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = i_data;
            flush_d          = 1'b1;
            state_d          = ST_FLUSH;
            cnt_d            = CNT_LOAD;
          end
          WB_REFETCH: begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = i_instr.pc;
            flush_d          = 1'b1;
            state_d          = ST_FLUSH;
            cnt_d            = CNT_LOAD;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_FLUSH: begin
        // Flush stays high through the cycle in which the counter reaches zero.
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          flush_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 4'd0;
      rf_wen_q         <= 1'b0;
      rf_idx_q         <= 5'd0;
      rf_data_q        <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      instret_inc_q    <= 1'b0;
      retired_q        <= 64'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      rf_wen_q         <= rf_wen_d;
      rf_idx_q         <= rf_idx_d;
      rf_data_q        <= rf_data_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      instret_inc_q    <= instret_inc_d;
      retired_q        <= retired_d;
    end
  end

  assign o_rf_wen         = rf_wen_q;
  assign o_rf_idx         = rf_idx_q;
  assign o_rf_data        = rf_data_q;
  assign o_flush          = flush_q;
  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_instret_inc    = instret_inc_q;
  assign o_retired        = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int FC = 2;

  logic          i_clk;
  logic          i_rst;
  issued_instr_t i_instr;
  reg_data_t     i_data;
  logic          o_rf_wen;
  logic [4:0]    o_rf_idx;
  reg_data_t     o_rf_data;
  logic          o_flush;
  logic          o_redirect_valid;
  reg_data_t     o_redirect_pc;
  logic          o_instret_inc;
  logic [63:0]   o_retired;

  writeback_stage #(.FLUSH_CYCLES(FC)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_instr          (i_instr),
    .i_data           (i_data),
    .o_rf_wen         (o_rf_wen),
    .o_rf_idx         (o_rf_idx),
    .o_rf_data        (o_rf_data),
    .o_flush          (o_flush),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .o_instret_inc    (o_instret_inc),
    .o_retired        (o_retired)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Reference model state: what every output must read after the last edge.
  logic        m_rf_wen = 1'b0;
  logic [4:0]  m_rf_idx = 5'd0;
  reg_data_t   m_rf_data = '0;
  logic        m_flush = 1'b0;
  logic        m_redir = 1'b0;
  reg_data_t   m_redir_pc = '0;
  logic        m_instret = 1'b0;
  logic [63:0] m_retired = 64'd0;
  int          busy = 0;   // edges still to be ignored after a redirect

  always @(posedge i_clk) begin
    m_rf_wen  = 1'b0;
    m_redir   = 1'b0;
    m_instret = 1'b0;
    if (i_rst) begin
      m_rf_idx = 5'd0; m_rf_data = '0; m_flush = 1'b0;
      m_redir_pc = '0; m_retired = 64'd0; busy = 0;
    end else if (busy > 0) begin
      busy = busy - 1;
      m_flush = (busy > 0);
    end else begin
      m_flush = 1'b0;
      if (i_instr.valid) begin
        if (!i_instr.except.valid || i_instr.except.code == EXCEPT_SYS) begin
          m_instret = 1'b1;
          m_retired = m_retired + 64'd1;
          if (i_instr.decode.rd_wen && i_instr.decode.rd != 5'd0) begin
            m_rf_wen = 1'b1; m_rf_idx = i_instr.decode.rd; m_rf_data = i_data;
          end
        end else if (i_instr.except.code == EXCEPT_MISPRED) begin
          m_instret = 1'b1;
          m_retired = m_retired + 64'd1;
          m_redir = 1'b1; m_redir_pc = i_data;
          m_flush = 1'b1; busy = FC;
        end else if (i_instr.except.code == EXCEPT_FLUSH) begin
          m_redir = 1'b1; m_redir_pc = i_instr.pc;
          m_flush = 1'b1; busy = FC;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      cmp("rf_wen", 64'(o_rf_wen), 64'(m_rf_wen));
      cmp("rf_idx", 64'(o_rf_idx), 64'(m_rf_idx));
      cmp("rf_data", 64'(o_rf_data), 64'(m_rf_data));
      cmp("flush", 64'(o_flush), 64'(m_flush));
      cmp("redirect_valid", 64'(o_redirect_valid), 64'(m_redir));
      cmp("redirect_pc", 64'(o_redirect_pc), 64'(m_redir_pc));
      cmp("instret_inc", 64'(o_instret_inc), 64'(m_instret));
      cmp("retired", o_retired, m_retired);
    end
  end

  task automatic cyc(input issued_instr_t ins, input reg_data_t d);
    @(negedge i_clk);
    i_instr = ins;
    i_data  = d;
    @(posedge i_clk);
    #1;
  endtask

  function automatic issued_instr_t alu(input logic [4:0] rd);
    return compose_issued_instr(1'b1, 32'h0000_1000, rd, 1'b1, 1'b0, EXCEPT_NONE);
  endfunction

  function automatic issued_instr_t exc(input except_code_t c, input reg_data_t pc);
    return compose_issued_instr(1'b1, pc, 5'd9, 1'b1, 1'b1, c);
  endfunction

  issued_instr_t nop;
  except_code_t  codes [5];

  initial begin
    codes = '{EXCEPT_MISPRED, EXCEPT_FLUSH, EXCEPT_SYS, EXCEPT_ILLEGAL, EXCEPT_FAULT};
    nop = compose_issued_instr(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, EXCEPT_NONE);
    i_rst = 1'b1; i_instr = nop; i_data = '0;
    cyc(nop, 32'h0);
    cyc(nop, 32'h0);
    chk_en = 1'b1;
    cmp("reset_wen", 64'(o_rf_wen), 64'd0);
    cmp("reset_flush", 64'(o_flush), 64'd0);
    cmp("reset_retired", o_retired, 64'd0);
    i_rst = 1'b0;

    cyc(alu(5'd5), 32'h0000_1234);
    cmp("alu_wen", 64'(o_rf_wen), 64'd1);
    cmp("alu_idx", 64'(o_rf_idx), 64'd5);
    cmp("alu_data", 64'(o_rf_data), 64'h1234);
    cmp("alu_instret", 64'(o_instret_inc), 64'd1);
    cmp("alu_retired", o_retired, 64'd1);

    cyc(alu(5'd0), 32'h0000_BEEF);
    cmp("x0_wen", 64'(o_rf_wen), 64'd0);
    cmp("x0_retired", o_retired, 64'd2);

    cyc(exc(EXCEPT_MISPRED, 32'h0000_0040), 32'h8000_0100);
    cmp("mp_redir", 64'(o_redirect_valid), 64'd1);
    cmp("mp_pc", 64'(o_redirect_pc), 64'h8000_0100);
    cmp("mp_flush1", 64'(o_flush), 64'd1);
    cmp("mp_retired", o_retired, 64'd3);
    cyc(alu(5'd7), 32'h0000_0777);
    cmp("mp_flush2", 64'(o_flush), 64'd1);
    cmp("mp_redir_pulse", 64'(o_redirect_valid), 64'd0);
    cmp("mp_ign1_wen", 64'(o_rf_wen), 64'd0);
    cyc(alu(5'd8), 32'h0000_0888);
    cmp("mp_flush_end", 64'(o_flush), 64'd0);
    cmp("mp_ign2_wen", 64'(o_rf_wen), 64'd0);
    cmp("mp_ign_retired", o_retired, 64'd3);
    cyc(nop, 32'h0);

    cyc(exc(EXCEPT_FLUSH, 32'h0000_0200), 32'h0000_5555);
    cmp("rf_redir", 64'(o_redirect_valid), 64'd1);
    cmp("rf_pc", 64'(o_redirect_pc), 64'h200);
    cmp("rf_noretire", o_retired, 64'd3);
    cmp("rf_noinstret", 64'(o_instret_inc), 64'd0);
    cyc(exc(EXCEPT_MISPRED, 32'h0000_0300), 32'h0000_DEAD);
    cmp("rf_mp_ignored", 64'(o_redirect_valid), 64'd0);
    cmp("rf_pc_hold", 64'(o_redirect_pc), 64'h200);
    cyc(nop, 32'h0);
    cyc(nop, 32'h0);

    // Preload the retire counter to its maximum, then commit once more.
    @(negedge i_clk);
    force dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_retired = 64'hFFFF_FFFF_FFFF_FFFF;
    i_instr = alu(5'd1);
    i_data  = 32'h0000_0001;
    #1;
    release dut.retired_q;
    @(posedge i_clk);
    #1;
    cmp("wrap_retired", o_retired, 64'd0);
    cmp("wrap_instret", 64'(o_instret_inc), 64'd1);

    cyc(exc(EXCEPT_MISPRED, 32'h0000_0010), 32'h8000_0200);
    cyc(nop, 32'h0);
    cmp("rst_mid_flush2", 64'(o_flush), 64'd1);
    i_rst = 1'b1;
    cyc(nop, 32'h0);
    cmp("rst_flush", 64'(o_flush), 64'd0);
    cmp("rst_pc", 64'(o_redirect_pc), 64'd0);
    cmp("rst_retired", o_retired, 64'd0);
    i_rst = 1'b0;
    cyc(alu(5'd3), 32'h0000_0055);
    cmp("post_rst_wen", 64'(o_rf_wen), 64'd1);
    cmp("post_rst_data", 64'(o_rf_data), 64'h55);
    cmp("post_rst_retired", o_retired, 64'd1);

    for (int n = 0; n < 600; n++) begin
      logic          v, ev, we;
      except_code_t  c;
      issued_instr_t ins;
      v  = ($urandom_range(9) < 8);
      ev = ($urandom_range(9) < 3);
      we = ($urandom_range(3) != 0);
      c  = ev ? codes[$urandom_range(4)] : EXCEPT_NONE;
      ins = compose_issued_instr(v, reg_data_t'($urandom), 5'($urandom_range(31)), we, ev, c);
      i_rst = ($urandom_range(99) == 0);
      cyc(ins, reg_data_t'($urandom));
    end
    i_rst = 1'b0;
    cyc(nop, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
